// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the sequencer state encoding, the flush counter width,
// the instruction address width and the per-register hold bundle.
package pipe_stall_ctrl_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    DRAIN = 2'b10
  } stall_state_e;

  // One hold bit per pipeline register, PC first.
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } hold_t;

  // Counter value loaded when a flush window starts.
  function automatic logic [FLUSH_CNT_W-1:0] flush_reload(input int unsigned cycles);
    return FLUSH_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-control bundle between the pipeline and the stall sequencer.
// master: pipeline side (drives requests, receives hold/flush/redirect).
// slave : sequencer side.
// Requests : if_stall_req, id_loaduse_req, mem_stall_req, ex_branch_taken,
//            ex_branch_target[ADDR_W].
// Controls : pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
//            id_stall, branch_interception, pc_redirect, pc_redirect_addr.
interface pipe_stall_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              if_stall_req;
  logic              id_loaduse_req;
  logic              mem_stall_req;
  logic              ex_branch_taken;
  logic [ADDR_W-1:0] ex_branch_target;

  logic              pc_stall;
  logic              ifid_stall;
  logic              idex_stall;
  logic              exmem_stall;
  logic              memwb_stall;
  logic              id_stall;
  logic              branch_interception;
  logic              pc_redirect;
  logic [ADDR_W-1:0] pc_redirect_addr;

  modport master (
    output if_stall_req, id_loaduse_req, mem_stall_req, ex_branch_taken, ex_branch_target,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall, id_stall,
           branch_interception, pc_redirect, pc_redirect_addr
  );

  modport slave (
    input  if_stall_req, id_loaduse_req, mem_stall_req, ex_branch_taken, ex_branch_target,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall, id_stall,
           branch_interception, pc_redirect, pc_redirect_addr
  );

endinterface

// File: rtl/pipe_stall_ctrl_stall_perf_cnt.sv
// Stall/bubble/flush event counters for the stall sequencer.
// Present only when STALL_PERF_CNT_EN is defined.
// Ports: clk, rst (sync, active high), pc_stall, id_stall, flush_evt in;
//        perf_stall_cycles, perf_bubbles, perf_flushes (32-bit, wrapping) out.
`ifdef STALL_PERF_CNT_EN
module pipe_stall_ctrl_stall_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        id_stall,
  input  logic        flush_evt,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushes
);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_bubbles      <= '0;
      perf_flushes      <= '0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + 32'(pc_stall);
      perf_bubbles      <= perf_bubbles + 32'(id_stall);
      perf_flushes      <= perf_flushes + 32'(flush_evt);
    end
  end

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// Central hazard/stall/flush sequencer for the 5-stage pipeline.
// Ports: clk, rst (sync, active high); bus (pipe_stall_ctrl_if.slave) carrying
//        the IF/ID/MEM stall requests, EX branch resolution and all
//        hold/bubble/flush/redirect controls.
// Optional: STALL_PERF_CNT_EN adds perf_stall_cycles, perf_bubbles,
//           perf_flushes outputs.
// Hold/bubble/flush controls are combinational; pc_redirect and
// pc_redirect_addr are registered.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned ADDR_W       = INST_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_flushes
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] CNT_RELOAD = flush_reload(FLUSH_CYCLES);

  stall_state_e           state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   redirect_q, redirect_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  hold_t                  hold;
  logic                   bubble;
  logic                   flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      addr_q     <= addr_d;
    end
  end

  // Next state. A MEM stall freezes everything; a taken branch overrides
  // whatever window is in progress.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    addr_d     = addr_q;
    if (bus.mem_stall_req) begin
      state_d = state_q;
    end else if (bus.ex_branch_taken) begin
      redirect_d = 1'b1;
      addr_d     = bus.ex_branch_target;
      cnt_d      = CNT_RELOAD;
      if (bus.if_stall_req)      state_d = DRAIN;
      else if (FLUSH_CYCLES > 1) state_d = FLUSH;
      else                       state_d = RUN;
    end else begin
      case (state_q)
        RUN: ;
        FLUSH: begin
          // cnt counts the FLUSH cycles still owed, including this one
          if (cnt_q <= FLUSH_CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DRAIN: begin
          // Stale fetch has landed: re-issue the redirect and flush behind it
          if (!bus.if_stall_req) begin
            redirect_d = 1'b1;
            cnt_d      = CNT_RELOAD;
            state_d    = FLUSH;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Hold, bubble and flush controls
  always_comb begin
    hold   = '0;
    bubble = 1'b0;
    flush  = 1'b0;
    if (!rst) begin
      if (bus.mem_stall_req) begin
        hold  = '1;
        flush = (state_q != RUN);
      end else if (bus.ex_branch_taken) begin
        hold.pc = 1'b1;
        flush   = 1'b1;
      end else begin
        case (state_q)
          FLUSH: flush = 1'b1;
          DRAIN: begin
            flush   = 1'b1;
            hold.pc = bus.if_stall_req;
          end
          default: begin
            if (bus.id_loaduse_req) begin
              hold.pc   = 1'b1;
              hold.ifid = 1'b1;
              bubble    = 1'b1;
            end else if (bus.if_stall_req) begin
              hold.pc = 1'b1;
              bubble  = 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.pc_stall            = hold.pc;
  assign bus.ifid_stall          = hold.ifid;
  assign bus.idex_stall          = hold.idex;
  assign bus.exmem_stall         = hold.exmem;
  assign bus.memwb_stall         = hold.memwb;
  assign bus.id_stall            = bubble;
  assign bus.branch_interception = flush;
  assign bus.pc_redirect         = redirect_q;
  assign bus.pc_redirect_addr    = addr_q;

`ifdef STALL_PERF_CNT_EN
  // A branch accepted while running opens a new flush window
  logic flush_evt;
  assign flush_evt = !rst && (state_q == RUN) && !bus.mem_stall_req && bus.ex_branch_taken;

  pipe_stall_ctrl_stall_perf_cnt u_perf (
    .clk               (clk),
    .rst               (rst),
    .pc_stall          (hold.pc),
    .id_stall          (bubble),
    .flush_evt         (flush_evt),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_bubbles      (perf_bubbles),
    .perf_flushes      (perf_flushes)
  );
`endif

endmodule
